// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two issue slots, with multiply wait sequencing.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make req0 always win ties instead of round-robin.
module alu_issue_arbiter #(
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [5:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [5:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [5:0]       alu_op,
  output logic             alu_sel,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_src,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_branch,
  output logic             resp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  localparam logic [5:0] OP_NONE  = 6'b111111;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             any_req, gnt_src, is_mul;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb gnt_src = ~req0_valid;
`else
  logic rr_last_q, rr_last_d;

  // On a tie the requester that did not win last time is served.
  always_comb gnt_src = (req0_valid & req1_valid) ? ~rr_last_q : ~req0_valid;

  always_comb rr_last_d = (state_q == IDLE && any_req) ? gnt_src : rr_last_q;

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end
`endif

  always_comb begin
    any_req      = req0_valid | req1_valid;
    is_mul       = (op_q == 6'b000100) || (op_q == 6'b000101);
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    alu_op       = op_q;
    alu_sel      = src_q;
    resp_valid   = 1'b0;
    resp_src     = 1'b0;
    resp_tag     = '0;
    resp_branch  = 1'b0;
    resp_illegal = 1'b0;
    case (state_q)
      IDLE: begin
        alu_op  = OP_NONE;
        alu_sel = 1'b0;
        if (any_req) begin
          req0_ready = ~gnt_src;
          req1_ready = gnt_src;
          op_d       = gnt_src ? req1_op : req0_op;
          tag_d      = gnt_src ? req1_tag : req0_tag;
          src_d      = gnt_src;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (is_mul) begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        // Operands and opcode stay applied so the ALU keeps producing the same result.
        resp_valid   = 1'b1;
        resp_src     = src_q;
        resp_tag     = tag_q;
        resp_branch  = (op_q >= 6'b001110) && (op_q <= 6'b010000);
        resp_illegal = (op_q > 6'b010000);
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      tag_q   <= '0;
      src_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: vector table, directed corner sequences, random vs. reference model.
module tb_alu_issue_arbiter;
  localparam int MUL_LAT = 3;
  localparam int TAG_W   = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0] req0_op, req1_op, alu_op;
  logic [TAG_W-1:0] req0_tag, req1_tag, resp_tag;
  logic alu_sel, resp_valid, resp_ready, resp_src, resp_branch, resp_illegal;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_tag(req1_tag),
    .alu_op(alu_op), .alu_sel(alu_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src),
    .resp_tag(resp_tag), .resp_branch(resp_branch), .resp_illegal(resp_illegal)
  );

  typedef struct {
    logic rst, v0; logic [5:0] op0; logic [3:0] tag0;
    logic v1; logic [5:0] op1; logic [3:0] tag1; logic rdy;
    logic r0, r1; logic [5:0] aop; logic sel; logic rv, src; logic [3:0] tag; logic br, ill;
    logic chk_resp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [5:0] o0, input logic [3:0] t0,
                       input logic v1, input logic [5:0] o1, input logic [3:0] t1, input logic rdy);
    @(negedge clk);
    rst = r; req0_valid = v0; req0_op = o0; req0_tag = t0;
    req1_valid = v1; req1_op = o1; req1_tag = t1; resp_ready = rdy;
    #1;
  endtask

  function automatic vec_t mk(logic r, logic v0, logic [5:0] o0, logic [3:0] t0,
                              logic v1, logic [5:0] o1, logic [3:0] t1, logic rdy,
                              logic r0, logic r1, logic [5:0] aop, logic sel, logic rv,
                              logic src, logic [3:0] tag, logic br, logic ill, logic cr);
    vec_t v;
    v.rst = r; v.v0 = v0; v.op0 = o0; v.tag0 = t0; v.v1 = v1; v.op1 = o1; v.tag1 = t1; v.rdy = rdy;
    v.r0 = r0; v.r1 = r1; v.aop = aop; v.sel = sel; v.rv = rv; v.src = src; v.tag = tag;
    v.br = br; v.ill = ill; v.chk_resp = cr;
    return v;
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 6'b000100;
      1:       return 6'b000101;
      2:       return 6'($urandom_range(14, 16));
      3:       return 6'($urandom_range(17, 63));
      default: return 6'($urandom_range(0, 13));
    endcase
  endfunction

  // Reference model state: transaction-level view of the arbiter.
  bit m_busy, m_resp, m_last, m_src, m_win;
  int m_timer;
  logic [5:0] m_op;
  logic [3:0] m_tag;

  initial begin
    logic s, rv0, rv1, rr, rrdy, m_idle, m_any;
    logic [5:0] o0, o1, sop;
    logic [3:0] t0, t1, stag;

    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_tag = 0; req1_tag = 0; resp_ready = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset state, then a lone req0 single-cycle op.
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 6'h3F, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 6'h00, 3, 0, 0, 0, 1,  1, 0, 6'h3F, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 6'h00, 3, 0, 0, 0, 1,  0, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 6'h00, 3, 0, 0, 0, 1,  0, 0, 6'h00, 0, 1, 0, 3, 0, 0, 1));
    vq.push_back(mk(0, 0, 6'h00, 3, 0, 0, 0, 1,  0, 0, 6'h3F, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 6'h3F, 0, 0, 0, 0, 0, 0, 0));
    // Both requesters continuously valid: one grant every 3 cycles.
    for (int k = 0; k < 4; k++) begin
      s    = FIXED ? 1'b0 : 1'(k % 2);
      sop  = s ? 6'h08 : 6'h06;
      stag = s ? 4'd2 : 4'd1;
      vq.push_back(mk(0, 1, 6'h06, 1, 1, 6'h08, 2, 1,  ~s, s, 6'h3F, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 1, 6'h06, 1, 1, 6'h08, 2, 1,  0, 0, sop, s, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 1, 6'h06, 1, 1, 6'h08, 2, 1,  0, 0, sop, s, 1, s, stag, 0, 0, 1));
    end

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].v0, vq[i].op0, vq[i].tag0, vq[i].v1, vq[i].op1, vq[i].tag1, vq[i].rdy);
      chk($sformatf("vec%0d req0_ready", i), req0_ready, vq[i].r0);
      chk($sformatf("vec%0d req1_ready", i), req1_ready, vq[i].r1);
      chk($sformatf("vec%0d alu_op", i), alu_op, vq[i].aop);
      chk($sformatf("vec%0d resp_valid", i), resp_valid, vq[i].rv);
      if (vq[i].aop != 6'h3F || vq[i].chk_resp)
        chk($sformatf("vec%0d alu_sel", i), alu_sel, vq[i].sel);
      if (vq[i].rv || vq[i].chk_resp) begin
        chk($sformatf("vec%0d resp_src", i), resp_src, vq[i].src);
        chk($sformatf("vec%0d resp_tag", i), resp_tag, vq[i].tag);
        chk($sformatf("vec%0d resp_branch", i), resp_branch, vq[i].br);
        chk($sformatf("vec%0d resp_illegal", i), resp_illegal, vq[i].ill);
      end
    end

    // Multiply on req1: opcode held through WAIT, response MUL_LAT+1 cycles after grant.
    drive(0, 0, 0, 0, 1, 6'h04, 5, 1);
    chk("mul grant", req1_ready, 1);
    for (int i = 1; i <= MUL_LAT; i++) begin
      drive(0, 0, 0, 0, 0, 6'h04, 5, 1);
      chk($sformatf("mul c%0d alu_op", i), alu_op, 6'h04);
      chk($sformatf("mul c%0d alu_sel", i), alu_sel, 1);
      chk($sformatf("mul c%0d resp_valid", i), resp_valid, 0);
    end
    drive(0, 0, 0, 0, 0, 6'h04, 5, 1);
    chk("mul resp_valid", resp_valid, 1);
    chk("mul resp_tag", resp_tag, 5);
    chk("mul resp_src", resp_src, 1);
    chk("mul resp alu_op", alu_op, 6'h04);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("mul done resp_valid", resp_valid, 0);
    chk("mul done alu_op", alu_op, 6'h3F);

    // Branch with five cycles of backpressure.
    drive(0, 1, 6'h0F, 7, 0, 0, 0, 0);
    chk("br grant", req0_ready, 1);
    drive(0, 0, 6'h0F, 7, 0, 0, 0, 0);
    chk("br exec alu_op", alu_op, 6'h0F);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 6'h0F, 7, 0, 0, 0, 0);
      chk($sformatf("br hold%0d resp_valid", i), resp_valid, 1);
      chk($sformatf("br hold%0d resp_tag", i), resp_tag, 7);
      chk($sformatf("br hold%0d resp_branch", i), resp_branch, 1);
      chk($sformatf("br hold%0d alu_op", i), alu_op, 6'h0F);
    end
    drive(0, 0, 6'h0F, 7, 0, 0, 0, 1);
    chk("br accept resp_valid", resp_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("br after resp_valid", resp_valid, 0);
    chk("br after alu_op", alu_op, 6'h3F);

    // Illegal opcode: single-cycle latency, flagged.
    drive(0, 1, 6'h16, 9, 0, 0, 0, 1);
    chk("ill grant", req0_ready, 1);
    drive(0, 0, 6'h16, 9, 0, 0, 0, 1);
    chk("ill exec resp_valid", resp_valid, 0);
    drive(0, 0, 6'h16, 9, 0, 0, 0, 1);
    chk("ill resp_valid", resp_valid, 1);
    chk("ill resp_illegal", resp_illegal, 1);
    chk("ill resp_branch", resp_branch, 0);
    chk("ill resp_tag", resp_tag, 9);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("ill done resp_valid", resp_valid, 0);

    // Reset during a req0 multiply's WAIT: aborted, req0 wins the next tie.
    drive(0, 1, 6'h05, 10, 0, 0, 0, 1);
    chk("abort grant", req0_ready, 1);
    drive(0, 0, 6'h05, 10, 0, 0, 0, 1);
    drive(1, 0, 6'h05, 10, 0, 0, 0, 1);
    chk("abort wait alu_op", alu_op, 6'h05);
    drive(0, 1, 6'h00, 11, 1, 6'h01, 12, 1);
    chk("abort idle alu_op", alu_op, 6'h3F);
    chk("abort idle resp_valid", resp_valid, 0);
    chk("abort req0_ready", req0_ready, 1);
    chk("abort req1_ready", req1_ready, 0);
    drive(0, 0, 6'h00, 11, 0, 0, 0, 1);
    chk("abort next exec resp_valid", resp_valid, 0);
    drive(0, 0, 6'h00, 11, 0, 0, 0, 1);
    chk("abort next resp_valid", resp_valid, 1);
    chk("abort next resp_tag", resp_tag, 11);
    chk("abort next resp_src", resp_src, 0);

    // Random traffic against the transaction-level model.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    m_busy = 0; m_resp = 0; m_last = 1; m_timer = 0; m_op = 0; m_tag = 0; m_src = 0;
    for (int c = 0; c < 800; c++) begin
      rr   = ($urandom_range(0, 59) == 0);
      rv0  = ($urandom_range(0, 2) != 0);
      rv1  = ($urandom_range(0, 2) != 0);
      o0   = pick_op(); o1 = pick_op();
      t0   = 4'($urandom); t1 = 4'($urandom);
      rrdy = ($urandom_range(0, 9) < 7);
      drive(rr, rv0, o0, t0, rv1, o1, t1, rrdy);

      m_idle = !m_busy && !m_resp;
      m_any  = rv0 || rv1;
      m_win  = (rv0 && rv1) ? (FIXED ? 1'b0 : !m_last) : !rv0;
      chk("rnd req0_ready", req0_ready, m_idle && m_any && !m_win);
      chk("rnd req1_ready", req1_ready, m_idle && m_any && m_win);
      chk("rnd alu_op", alu_op, m_idle ? 6'h3F : m_op);
      chk("rnd resp_valid", resp_valid, m_resp);
      if (!m_idle) chk("rnd alu_sel", alu_sel, m_src);
      if (m_resp) begin
        chk("rnd resp_src", resp_src, m_src);
        chk("rnd resp_tag", resp_tag, m_tag);
        chk("rnd resp_branch", resp_branch, (m_op >= 14 && m_op <= 16));
        chk("rnd resp_illegal", resp_illegal, (m_op > 16));
      end

      if (rr) begin
        m_busy = 0; m_resp = 0; m_last = 1;
      end else if (m_idle && m_any) begin
        m_src   = m_win;
        m_last  = m_win;
        m_op    = m_win ? o1 : o0;
        m_tag   = m_win ? t1 : t0;
        m_timer = ((m_op == 4 || m_op == 5) ? MUL_LAT + 1 : 2) - 1;
        m_busy  = 1;
      end else if (m_busy) begin
        m_timer--;
        if (m_timer == 0) begin
          m_busy = 0;
          m_resp = 1;
        end
      end else if (m_resp && rrdy) begin
        m_resp = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single registered ALU between two requesters (req0 = integer issue slot, req1 = branch/address issue slot).
- Arbitrates round-robin and drives the ALU opcode and operand-select mux.
- Sequences single-cycle ops and multi-cycle multiplies (op 000100/000101) through a small FSM.
- Returns a tagged completion to the winner over a valid/ready handshake.

Parameters:
- MUL_LAT, 3: cycles the ALU result needs for multiply ops after issue; legal range 2..15.
- TAG_W, 4: width of the requester transaction tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 granted this cycle.
- req0_op  in  6  requester 0 opcode.
- req0_tag  in  TAG_W  requester 0 tag.
- req1_valid / req1_ready / req1_op / req1_tag: same as req0, for requester 1.
- alu_op  out  6  opcode to ALU.
- alu_sel  out  1  operand mux select: 0 = req0 operands, 1 = req1 operands.
- resp_valid  out  1  ALU result (rd / A / pc_out_2_ex_out) is valid.
- resp_ready  in  1  consumer accepts the result.
- resp_src  out  1  which requester the result belongs to.
- resp_tag  out  TAG_W  tag of the completing op.
- resp_branch  out  1  completing op is BZ/BEQ/JR (001110/001111/010000).
- resp_illegal  out  1  completing op > 010000 (ALU default case: rd = A = 0).

Behaviour:
- One clock, clk. Synchronous active-high reset, rst; all state updates on the rising clk edge.
- Reset values:
  - state = IDLE.
  - alu_op = 6'b111111, alu_sel = 0.
  - resp_valid = 0, resp_src = 0, resp_tag = 0, resp_branch = 0, resp_illegal = 0.
  - rr_last = 1, so req0 wins the first tie.
  - Multiply counter cnt = 0.
- rst asserted in any state (including mid-multiply or RESP) aborts the op; next cycle matches the reset values. No response is emitted for the aborted op.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - req0_ready / req1_ready are combinational, asserted only in IDLE, at most one high.
  - One valid requester: it is granted.
  - Both valid: grant the requester != rr_last.
  - On grant, register op, tag and src; set rr_last = src; go to EXEC.
  - Neither valid: stay in IDLE, alu_op = 111111.
- EXEC (one cycle):
  - alu_op = captured op, alu_sel = src.
  - If op is 000100 or 000101: cnt = MUL_LAT-2, go to WAIT.
  - Otherwise go to RESP. The ALU registers the result on the edge leaving EXEC.
- WAIT:
  - alu_op and alu_sel held.
  - cnt decrements each cycle; when cnt == 0, go to RESP.
  - Total grant-to-resp_valid latency: 2 cycles for non-multiply ops, MUL_LAT+1 cycles for multiplies.
- RESP:
  - resp_valid = 1; resp_src, resp_tag, resp_branch, resp_illegal stable.
  - alu_op and alu_sel held, so the ALU recomputes an identical result each cycle.
  - Stays in RESP while resp_ready = 0 (backpressure, unbounded).
  - resp_valid && resp_ready: go to IDLE; resp_valid drops the next cycle.
- Operand stability: the granted requester holds its operands stable from grant until its response handshake. The arbiter does not latch operands.
- Throughput: at most one op per 3 cycles. No new grant in EXEC, WAIT or RESP, even if resp_ready is already high.
- Invalid ops (> 010000) are treated as single-cycle; resp_illegal = 1.
- A request that drops valid while not granted is simply not serviced. There is no starvation: with both requesters continuously valid, grants alternate 0, 1, 0, 1.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: req0 always wins when both requesters are valid; rr_last is not used.
- Undefined: round-robin as specified above.
- Reset, latency and handshake behaviour are identical in both builds.

Test Plan:
- Only req0 valid, op 000000, tag 3, resp_ready = 1:
  - req0_ready high in cycle 0, EXEC in cycle 1.
  - resp_valid in cycle 2 with resp_src = 0, resp_tag = 3, resp_branch = 0; IDLE in cycle 3.
- Both valid continuously, ops 000110 / 001000, tags 1 / 2:
  - Grant order after reset is 0, 1, 0, 1.
  - resp_tag sequence 1, 2, 1, 2; one grant every 3 cycles.
  - With ALU_ARB_FIXED_PRIO_EN: grants 0, 0, 0, 0.
- req1 op 000100 with MUL_LAT = 3:
  - alu_op = 000100 held from EXEC through RESP.
  - resp_valid exactly 4 cycles after grant.
- Branch op 001111, resp_ready held low for 5 cycles:
  - resp_valid, resp_tag, resp_branch = 1 and alu_op all stable for 5 cycles.
  - Completes on the first cycle resp_ready = 1.
- Op 010110: resp_illegal = 1, single-cycle latency (resp_valid 2 cycles after grant).
- rst pulsed during WAIT of a multiply:
  - Next cycle: state IDLE, alu_op = 111111, resp_valid = 0.
  - No response for the aborted tag; the following req0 request is granted first.
